// File: rtl/fft_frame_unloader.sv
// Snapshots a full FFT result frame on frame_done and streams it out one bin per valid/ready beat.
// Optional macro FFT_UNLOAD_BITREV_EN: read the snapshot in bit-reversed slot order so the stream is natural order.
module fft_frame_unloader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_WIDTH-1:0][15:0] frame_Re,
  input  logic [D_WIDTH-1:0][15:0] frame_Im,
  input  logic                     frame_done,
  output logic                     frame_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_Re,
  output logic [15:0]              out_Im,
  output logic [LOG_2_WIDTH-1:0]   out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);
  localparam logic [LOG_2_WIDTH-1:0] CNT_ZERO = {LOG_2_WIDTH{1'b0}};
  localparam logic [LOG_2_WIDTH-1:0] CNT_ONE  = LOG_2_WIDTH'(1);

  function automatic logic [LOG_2_WIDTH-1:0] rd_addr(input logic [LOG_2_WIDTH-1:0] cnt);
    logic [LOG_2_WIDTH-1:0] addr;
`ifdef FFT_UNLOAD_BITREV_EN
    for (int i = 0; i < LOG_2_WIDTH; i++) begin
      addr[i] = cnt[LOG_2_WIDTH-1-i];
    end
`else
    addr = cnt;
`endif
    return addr;
  endfunction

  state_e                     state_q, state_d;
  logic [LOG_2_WIDTH-1:0]     cnt_q, cnt_d;
  logic [D_WIDTH-1:0][15:0]   buf_re_q, buf_re_d;
  logic [D_WIDTH-1:0][15:0]   buf_im_q, buf_im_d;
  logic                       frame_ack_q, frame_ack_d;
  logic                       out_valid_q, out_valid_d;
  logic [15:0]                out_re_q, out_re_d;
  logic [15:0]                out_im_q, out_im_d;
  logic [LOG_2_WIDTH-1:0]     out_index_q, out_index_d;
  logic                       out_last_q, out_last_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;
  logic                       xfer;
  logic                       last_xfer;
  logic                       capture;

  // Next-state, snapshot capture and registered-output precompute.
  always_comb begin
    xfer      = out_valid_q && out_ready;
    last_xfer = xfer && (cnt_q == LAST_IDX);
    capture   = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          capture = 1'b1;
        end else begin
          capture = 1'b0;
        end
      end
      ST_STREAM: begin
        if (last_xfer) begin
          // A frame arriving on the final beat is taken without a bubble.
          if (frame_done) begin
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
          if (frame_done) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    if (capture) begin
      buf_re_d = frame_Re;
      buf_im_d = frame_Im;
      state_d  = ST_STREAM;
      cnt_d    = CNT_ZERO;
    end else begin
      buf_re_d = buf_re_q;
      buf_im_d = buf_im_q;
    end

    frame_ack_d = capture;
    out_valid_d = (state_d == ST_STREAM);
    busy_d      = out_valid_d;

    if (out_valid_d) begin
      out_re_d    = buf_re_d[rd_addr(cnt_d)];
      out_im_d    = buf_im_d[rd_addr(cnt_d)];
      out_index_d = cnt_d;
      out_last_d  = (cnt_d == LAST_IDX);
    end else begin
      out_re_d    = 16'h0000;
      out_im_d    = 16'h0000;
      out_index_d = CNT_ZERO;
      out_last_d  = 1'b0;
    end
  end

  // State and output registers, updated on the falling edge like the FFT core.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      buf_re_q    <= '{default: 16'h0000};
      buf_im_q    <= '{default: 16'h0000};
      frame_ack_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= 16'h0000;
      out_im_q    <= 16'h0000;
      out_index_q <= CNT_ZERO;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_re_q    <= buf_re_d;
      buf_im_q    <= buf_im_d;
      frame_ack_q <= frame_ack_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_ack = frame_ack_q;
  assign out_valid = out_valid_q;
  assign out_Re    = out_re_q;
  assign out_Im    = out_im_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
